// File: rtl/dma_axi_master_if.sv
// Bundle of the engine-side request/data channels and the AXI4 master
// channels used by dma_axi_master. The adapter connects through the
// master modport; whatever sits around it (engine plus memory model)
// connects through the slave modport.
interface dma_axi_master_if #(
  parameter int DATA_WIDTH = 32
);
  // engine read request and read data
  logic [31:0]             rd_req_addr;
  logic [4:0]              rd_req_len;
  logic                    rd_req_valid;
  logic                    rd_req_ready;
  logic [DATA_WIDTH-1:0]   rd_rdata;
  logic                    rd_last;
  logic                    rd_valid;
  logic                    rd_ready;

  // engine write request and write data
  logic [31:0]             wr_req_addr;
  logic [4:0]              wr_req_len;
  logic                    wr_req_valid;
  logic                    wr_req_ready;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_valid;
  logic                    wr_last;
  logic                    wr_ready;

  // AXI read address / read data
  logic [31:0]             m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  // AXI write address / write data / write response
  logic [31:0]             m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  // status
  logic                    err;
  logic                    busy;

  modport master (
    input  rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
    output rd_req_ready, rd_rdata, rd_last, rd_valid,
    input  wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
    output wr_req_ready, wr_ready,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output err, busy
  );

  modport slave (
    output rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
    input  rd_req_ready, rd_rdata, rd_last, rd_valid,
    output wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
    input  wr_req_ready, wr_ready,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  err, busy
  );
endinterface

// File: rtl/dma_axi_master.sv
// AXI4 master port adapter for the DMA engine. Independent read and
// write FSMs, one outstanding burst each, combinational data paths and
// a sticky error flag for bad responses and last/length mismatches.
//
// Handshake rule on every channel: a transfer happens in a cycle where
// valid and ready are both 1 at the rising edge. A valid, once raised,
// stays raised with its payload stable until that transfer; ready may
// come and go freely and may be raised in the same cycle as valid.
module dma_axi_master (
  input  logic                   clk,
  input  logic                   rst,
  dma_axi_master_if.master       bus,
  // debug view of the FSMs, 0 = idle
  output logic [1:0]             rd_state_dbg,
  output logic [1:0]             wr_state_dbg
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } w_state_e;

  r_state_e    r_state, r_next;
  w_state_e    w_state, w_next;

  logic [31:0] r_addr, w_addr;
  logic [4:0]  r_len, w_len;
  logic [4:0]  r_cnt, w_cnt;
  logic        err_q;

  logic        r_accept, r_beat, r_err;
  logic        w_accept, w_beat, w_resp, w_err;

  // ---------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------

  // read FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // read FSM next state and channel gating
  always_comb begin
    r_next             = r_state;
    bus.rd_req_ready   = 1'b0;
    bus.m_axi_arvalid  = 1'b0;
    bus.rd_valid       = 1'b0;
    bus.rd_last        = 1'b0;
    bus.m_axi_rready   = 1'b0;
    r_accept           = 1'b0;
    r_beat             = 1'b0;
    case (r_state)
      R_IDLE: begin
        // held low while rst is asserted so nothing is accepted in reset
        bus.rd_req_ready = !rst;
        r_accept         = bus.rd_req_valid && !rst;
        if (r_accept) r_next = R_ADDR;
      end
      R_ADDR: begin
        bus.m_axi_arvalid = 1'b1;
        if (bus.m_axi_arready) r_next = R_DATA;
      end
      R_DATA: begin
        bus.rd_valid     = bus.m_axi_rvalid;
        bus.rd_last      = bus.m_axi_rlast;
        bus.m_axi_rready = bus.rd_ready;
        r_beat           = bus.m_axi_rvalid && bus.rd_ready;
        if (r_beat && bus.m_axi_rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // a beat is bad if it carries an error response, or if rlast does not
  // coincide with the beat numbered len
  always_comb begin
    r_err = r_beat && ((bus.m_axi_rresp != 2'b00) ||
                       (bus.m_axi_rlast != (r_cnt == r_len)));
  end

  // read request latch and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= 32'd0;
      r_len  <= 5'd0;
      r_cnt  <= 5'd0;
    end else if (r_accept) begin
      r_addr <= bus.rd_req_addr;
      r_len  <= bus.rd_req_len;
      r_cnt  <= 5'd0;
    end else if (r_beat && (r_cnt != 5'd31)) begin
      // saturate so an overlong burst keeps reporting the mismatch
      r_cnt  <= r_cnt + 5'd1;
    end
  end

  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arlen   = {3'b000, r_len};
  assign bus.m_axi_arsize  = 3'b010;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.rd_rdata      = bus.m_axi_rdata;

  // ---------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------

  // write FSM state register
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // write FSM next state and channel gating
  always_comb begin
    w_next            = w_state;
    bus.wr_req_ready  = 1'b0;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_wlast   = 1'b0;
    bus.wr_ready      = 1'b0;
    bus.m_axi_bready  = 1'b0;
    w_accept          = 1'b0;
    w_beat            = 1'b0;
    w_resp            = 1'b0;
    case (w_state)
      W_IDLE: begin
        bus.wr_req_ready = !rst;
        w_accept         = bus.wr_req_valid && !rst;
        if (w_accept) w_next = W_ADDR;
      end
      W_ADDR: begin
        bus.m_axi_awvalid = 1'b1;
        if (bus.m_axi_awready) w_next = W_DATA;
      end
      W_DATA: begin
        bus.m_axi_wvalid = bus.wr_valid;
        bus.m_axi_wlast  = bus.wr_last;
        bus.wr_ready     = bus.m_axi_wready;
        w_beat           = bus.wr_valid && bus.m_axi_wready;
        if (w_beat && bus.wr_last) w_next = W_RESP;
      end
      W_RESP: begin
        bus.m_axi_bready = 1'b1;
        w_resp           = bus.m_axi_bvalid;
        if (w_resp) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // write errors: wlast/length mismatch on a beat, or an error response
  always_comb begin
    w_err = (w_beat && (bus.wr_last != (w_cnt == w_len))) ||
            (w_resp && (bus.m_axi_bresp != 2'b00));
  end

  // write request latch and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr <= 32'd0;
      w_len  <= 5'd0;
      w_cnt  <= 5'd0;
    end else if (w_accept) begin
      w_addr <= bus.wr_req_addr;
      w_len  <= bus.wr_req_len;
      w_cnt  <= 5'd0;
    end else if (w_beat && (w_cnt != 5'd31)) begin
      w_cnt  <= w_cnt + 5'd1;
    end
  end

  assign bus.m_axi_awaddr  = w_addr;
  assign bus.m_axi_awlen   = {3'b000, w_len};
  assign bus.m_axi_awsize  = 3'b010;
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_wdata   = bus.wr_data;
  assign bus.m_axi_wstrb   = '1;

  // ---------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------

  // sticky error flag; transfers carry on normally after it is set
  always_ff @(posedge clk) begin
    if (rst)                 err_q <= 1'b0;
    else if (r_err || w_err) err_q <= 1'b1;
  end

  assign bus.err      = err_q;
  assign bus.busy     = (r_state != R_IDLE) || (w_state != W_IDLE);
  assign rd_state_dbg = r_state;
  assign wr_state_dbg = w_state;

endmodule

// File: tb/tb_dma_axi_master.sv
// Bench for dma_axi_master: a table of directed bursts, a hand-written
// reset-mid-burst sequence and randomized bursts checked against a
// transaction-level model of the expected beats and error flag.
module tb_dma_axi_master;

  logic       clk;
  logic       rst;
  logic [1:0] rd_state_dbg;
  logic [1:0] wr_state_dbg;

  dma_axi_master_if #(.DATA_WIDTH(32)) bus ();

  dma_axi_master dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rd_state_dbg (rd_state_dbg),
    .wr_state_dbg (wr_state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rexp_q[$];
  logic [31:0] wexp_q[$];

  localparam int CYCLE_LIMIT = 3000;

  typedef struct {
    bit          do_rd;
    logic [31:0] rd_addr;
    logic [4:0]  rd_len;
    int          rd_last_beat;  // beat index that carries rlast
    int          rd_bad_beat;   // beat index with rresp=2'b10, -1 for none
    logic [31:0] rd_base;       // rdata of beat i is rd_base+i
    int          ar_dly;        // cycles of arvalid before arready
    bit          do_wr;
    logic [31:0] wr_addr;
    logic [4:0]  wr_len;
    int          wr_last_beat;  // beat index the engine marks wr_last
    logic [1:0]  bresp;
    logic [31:0] wr_base;
    int          aw_dly;
    int          b_dly;         // cycles in response phase before bvalid
    bit          stall;         // random valid/ready gaps on data channels
    bit          exp_err;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit do_rd, logic [31:0] ra, logic [4:0] rl, int rlast, int rbad,
                              int ar_dly, bit do_wr, logic [31:0] wa, logic [4:0] wl, int wlast,
                              logic [1:0] bresp, int b_dly, bit stall, bit exp_err);
    vec_t v;
    v.do_rd = do_rd; v.rd_addr = ra; v.rd_len = rl; v.rd_last_beat = rlast;
    v.rd_bad_beat = rbad; v.rd_base = 32'hA0; v.ar_dly = ar_dly;
    v.do_wr = do_wr; v.wr_addr = wa; v.wr_len = wl; v.wr_last_beat = wlast;
    v.bresp = bresp; v.wr_base = 32'h0; v.aw_dly = ar_dly; v.b_dly = b_dly;
    v.stall = stall; v.exp_err = exp_err;
    return v;
  endfunction

  // Reference for the error flag: any error-response beat that is actually
  // transferred, any burst whose last marker is not on beat len, any bad bresp.
  function automatic bit model_err(vec_t v);
    bit e;
    e = 1'b0;
    if (v.do_rd && ((v.rd_bad_beat >= 0 && v.rd_bad_beat <= v.rd_last_beat) ||
                    (v.rd_last_beat != int'(v.rd_len)))) e = 1'b1;
    if (v.do_wr && ((v.bresp != 2'b00) || (v.wr_last_beat != int'(v.wr_len)))) e = 1'b1;
    return e;
  endfunction

  function automatic bit coin(bit stall);
    return stall ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic quiet_inputs();
    bus.rd_req_addr = '0; bus.rd_req_len = '0; bus.rd_req_valid = 1'b0; bus.rd_ready = 1'b0;
    bus.wr_req_addr = '0; bus.wr_req_len = '0; bus.wr_req_valid = 1'b0;
    bus.wr_data = '0; bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
    bus.m_axi_arready = 1'b0; bus.m_axi_rdata = '0; bus.m_axi_rresp = '0;
    bus.m_axi_rlast = 1'b0; bus.m_axi_rvalid = 1'b0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bresp = '0; bus.m_axi_bvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " arvalid"}, 32'(bus.m_axi_arvalid), 0);
    check({tag, " awvalid"}, 32'(bus.m_axi_awvalid), 0);
    check({tag, " wvalid"}, 32'(bus.m_axi_wvalid), 0);
    check({tag, " rready"}, 32'(bus.m_axi_rready), 0);
    check({tag, " bready"}, 32'(bus.m_axi_bready), 0);
    check({tag, " wr_ready"}, 32'(bus.wr_ready), 0);
    check({tag, " rd_valid"}, 32'(bus.rd_valid), 0);
    check({tag, " rd_req_ready"}, 32'(bus.rd_req_ready), 0);
    check({tag, " wr_req_ready"}, 32'(bus.wr_req_ready), 0);
    check({tag, " err"}, 32'(bus.err), 0);
    check({tag, " busy"}, 32'(bus.busy), 0);
  endtask

  // two reset cycles; outputs are checked in the second, after a reset edge
  task automatic do_reset();
    rst = 1'b1;
    quiet_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset araddr", bus.m_axi_araddr, 0);
    check("reset awaddr", bus.m_axi_awaddr, 0);
    check("reset arlen", 32'(bus.m_axi_arlen), 0);
    check("reset awlen", 32'(bus.m_axi_awlen), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Runs one read and/or write burst cycle by cycle. The bench plays both
  // the engine and the AXI slave; phases track where each burst should be.
  // Read phases: 0 request, 1 address, 2 data, 3 done.
  // Write phases: 0 request, 1 address, 2 data, 3 response, 4 done.
  task automatic run_vec(input vec_t v);
    int rph, wph, ridx, widx, arc, awc, bc, cyc;
    bit rdone, wdone;
    logic [31:0] e;
    rph = v.do_rd ? 0 : 3;
    wph = v.do_wr ? 0 : 4;
    ridx = 0; widx = 0; arc = 0; awc = 0; bc = 0; cyc = 0;
    rdone = 1'b0; wdone = 1'b0;
    rexp_q.delete();
    wexp_q.delete();
    if (v.do_rd) for (int i = 0; i <= v.rd_last_beat; i++) rexp_q.push_back(v.rd_base + 32'(i));
    if (v.do_wr) for (int i = 0; i <= v.wr_last_beat; i++) wexp_q.push_back(v.wr_base + 32'(i));

    while (!(rdone && wdone) && cyc < CYCLE_LIMIT) begin
      // drive: read side
      bus.rd_req_valid  = (rph == 0);
      bus.rd_req_addr   = v.rd_addr;
      bus.rd_req_len    = v.rd_len;
      bus.m_axi_arready = (rph == 1) && (arc >= v.ar_dly);
      bus.rd_ready      = coin(v.stall);
      if (rph == 2) begin
        bus.m_axi_rvalid = coin(v.stall);
        bus.m_axi_rdata  = v.rd_base + 32'(ridx);
        bus.m_axi_rresp  = (ridx == v.rd_bad_beat) ? 2'b10 : 2'b00;
        bus.m_axi_rlast  = (ridx == v.rd_last_beat);
      end else begin
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata  = $urandom;
        bus.m_axi_rresp  = 2'b00;
        bus.m_axi_rlast  = 1'b0;
      end
      // drive: write side (engine data is noisy outside the data phase)
      bus.wr_req_valid  = (wph == 0);
      bus.wr_req_addr   = v.wr_addr;
      bus.wr_req_len    = v.wr_len;
      bus.m_axi_awready = (wph == 1) && (awc >= v.aw_dly);
      bus.m_axi_wready  = coin(v.stall);
      if (wph == 2) begin
        bus.wr_valid = coin(v.stall);
        bus.wr_data  = v.wr_base + 32'(widx);
        bus.wr_last  = (widx == v.wr_last_beat);
      end else begin
        bus.wr_valid = ($urandom_range(0, 1) == 1);
        bus.wr_data  = $urandom;
        bus.wr_last  = ($urandom_range(0, 1) == 1);
      end
      bus.m_axi_bvalid = (wph == 3) && (bc >= v.b_dly);
      bus.m_axi_bresp  = v.bresp;

      @(negedge clk);
      check("busy", 32'(bus.busy), 32'((rph == 1) || (rph == 2) || (wph >= 1 && wph <= 3)));

      case (rph)
        0: begin
          check("rd_req_ready idle", 32'(bus.rd_req_ready), 1);
          check("rd_valid forced", 32'(bus.rd_valid), 0);
          check("rready forced", 32'(bus.m_axi_rready), 0);
          if (bus.rd_req_ready) rph = 1;
        end
        1: begin
          check("arvalid", 32'(bus.m_axi_arvalid), 1);
          check("araddr", bus.m_axi_araddr, v.rd_addr);
          check("arlen", 32'(bus.m_axi_arlen), 32'(v.rd_len));
          check("arsize", 32'(bus.m_axi_arsize), 2);
          check("arburst", 32'(bus.m_axi_arburst), 1);
          check("rd_req_ready busy", 32'(bus.rd_req_ready), 0);
          check("rd_valid in addr", 32'(bus.rd_valid), 0);
          if (bus.m_axi_arvalid && bus.m_axi_arready) rph = 2;
          else arc++;
        end
        2: begin
          check("rready follows rd_ready", 32'(bus.m_axi_rready), 32'(bus.rd_ready));
          check("rd_valid follows rvalid", 32'(bus.rd_valid), 32'(bus.m_axi_rvalid));
          check("arvalid in data", 32'(bus.m_axi_arvalid), 0);
          if (bus.m_axi_rvalid && bus.rd_ready) begin
            e = (rexp_q.size() != 0) ? rexp_q.pop_front() : 'x;
            check("rd_rdata", bus.rd_rdata, e);
            check("rd_last", 32'(bus.rd_last), 32'(ridx == v.rd_last_beat));
            if (ridx == v.rd_last_beat) rph = 3;
            ridx++;
          end
        end
        default: begin
          check("rd_req_ready after burst", 32'(bus.rd_req_ready), 1);
          check("arvalid after burst", 32'(bus.m_axi_arvalid), 0);
          check("rd_valid after burst", 32'(bus.rd_valid), 0);
          rdone = 1'b1;
        end
      endcase

      case (wph)
        0: begin
          check("wr_req_ready idle", 32'(bus.wr_req_ready), 1);
          check("wvalid forced", 32'(bus.m_axi_wvalid), 0);
          check("wr_ready forced", 32'(bus.wr_ready), 0);
          check("bready forced", 32'(bus.m_axi_bready), 0);
          if (bus.wr_req_ready) wph = 1;
        end
        1: begin
          check("awvalid", 32'(bus.m_axi_awvalid), 1);
          check("awaddr", bus.m_axi_awaddr, v.wr_addr);
          check("awlen", 32'(bus.m_axi_awlen), 32'(v.wr_len));
          check("awsize", 32'(bus.m_axi_awsize), 2);
          check("awburst", 32'(bus.m_axi_awburst), 1);
          check("wr_req_ready busy", 32'(bus.wr_req_ready), 0);
          check("wvalid in addr", 32'(bus.m_axi_wvalid), 0);
          if (bus.m_axi_awvalid && bus.m_axi_awready) wph = 2;
          else awc++;
        end
        2: begin
          check("wr_ready follows wready", 32'(bus.wr_ready), 32'(bus.m_axi_wready));
          check("wvalid follows wr_valid", 32'(bus.m_axi_wvalid), 32'(bus.wr_valid));
          check("bready in data", 32'(bus.m_axi_bready), 0);
          if (bus.wr_valid && bus.m_axi_wready) begin
            e = (wexp_q.size() != 0) ? wexp_q.pop_front() : 'x;
            check("wdata", bus.m_axi_wdata, e);
            check("wlast", 32'(bus.m_axi_wlast), 32'(widx == v.wr_last_beat));
            check("wstrb", 32'(bus.m_axi_wstrb), 32'hF);
            if (widx == v.wr_last_beat) wph = 3;
            widx++;
          end
        end
        3: begin
          check("bready", 32'(bus.m_axi_bready), 1);
          check("wvalid in resp", 32'(bus.m_axi_wvalid), 0);
          check("wr_ready in resp", 32'(bus.wr_ready), 0);
          if (bus.m_axi_bvalid) wph = 4;
          else bc++;
        end
        default: begin
          check("wr_req_ready after burst", 32'(bus.wr_req_ready), 1);
          check("awvalid after burst", 32'(bus.m_axi_awvalid), 0);
          check("bready after burst", 32'(bus.m_axi_bready), 0);
          check("wvalid after burst", 32'(bus.m_axi_wvalid), 0);
          wdone = 1'b1;
        end
      endcase

      @(posedge clk); #1;
      cyc++;
    end

    quiet_inputs();
    check("burst finished in budget", 32'(rdone && wdone), 1);
    check("rd beats all seen", 32'(rexp_q.size()), 0);
    check("wr beats all seen", 32'(wexp_q.size()), 0);
    check("err", 32'(bus.err), 32'(v.exp_err));
    check("rd fsm idle", 32'(rd_state_dbg), 0);
    check("wr fsm idle", 32'(wr_state_dbg), 0);
  endtask

  // Reset in the middle of a write data phase, with err already set.
  task automatic reset_mid_write();
    vec_t v;
    v = mk(1'b1, 32'h6000_0000, 5'd1, 1, 0, 0, 1'b0, 32'h0, 5'd0, 0, 2'b00, 0, 1'b0, 1'b1);
    do_reset();
    run_vec(v);

    bus.wr_req_addr  = 32'h7000_0000;
    bus.wr_req_len   = 5'd7;
    bus.wr_req_valid = 1'b1;
    @(negedge clk);
    check("rst test wr_req_ready", 32'(bus.wr_req_ready), 1);
    check("rst test err sticky", 32'(bus.err), 1);
    @(posedge clk); #1;
    bus.wr_req_valid  = 1'b0;
    bus.m_axi_awready = 1'b1;
    @(negedge clk);
    check("rst test awvalid", 32'(bus.m_axi_awvalid), 1);
    @(posedge clk); #1;
    bus.m_axi_awready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid     = 1'b1;
      bus.m_axi_wready = 1'b1;
      bus.wr_data      = 32'(i);
      bus.wr_last      = 1'b0;
      @(negedge clk);
      check("rst test wvalid mid burst", 32'(bus.m_axi_wvalid), 1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("mid-burst reset");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wr_valid     = 1'b0;
    bus.m_axi_wready = 1'b0;
    @(negedge clk);
    check("after reset wr_req_ready", 32'(bus.wr_req_ready), 1);
    check("after reset err", 32'(bus.err), 0);
    @(posedge clk); #1;
    v = mk(1'b0, 32'h0, 5'd0, 0, -1, 0, 1'b1, 32'h7000_0010, 5'd0, 0, 2'b00, 1, 1'b0, 1'b0);
    run_vec(v);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    vec_t v;
    rst = 1'b1;
    quiet_inputs();

    //           rd  addr           len  last bad ard  wr  addr           len  last bresp bd  stall err
    tbl[0] = mk(1, 32'h1000_0000, 5'd3,  3,  -1, 2,   0, 32'h0,         5'd0,  0, 2'b00, 0, 1, 0);
    tbl[1] = mk(0, 32'h0,         5'd0,  0,  -1, 1,   1, 32'h2000_0040, 5'd7,  7, 2'b00, 3, 1, 0);
    tbl[2] = mk(1, 32'h3000_0000, 5'd0,  0,  -1, 0,   1, 32'h4000_0100, 5'd15, 15, 2'b00, 1, 1, 0);
    tbl[3] = mk(1, 32'h1000_0100, 5'd3,  3,   1, 0,   0, 32'h0,         5'd0,  0, 2'b00, 0, 0, 1);
    tbl[4] = mk(0, 32'h0,         5'd0,  0,  -1, 0,   1, 32'h2000_0000, 5'd0,  0, 2'b11, 2, 0, 1);
    tbl[5] = mk(1, 32'h1000_0200, 5'd3,  2,  -1, 1,   0, 32'h0,         5'd0,  0, 2'b00, 0, 1, 1);
    tbl[6] = mk(1, 32'h5000_0000, 5'd31, 31, -1, 1,   0, 32'h0,         5'd0,  0, 2'b00, 0, 0, 0);
    tbl[7] = mk(0, 32'h0,         5'd0,  0,  -1, 0,   1, 32'h2000_1000, 5'd3,  5, 2'b00, 0, 1, 1);
    tbl[8] = mk(0, 32'h0,         5'd0,  0,  -1, 0,   1, 32'h2000_2000, 5'd4,  1, 2'b00, 1, 0, 1);
    tbl[9] = mk(1, 32'h1000_0300, 5'd2,  4,  -1, 0,   0, 32'h0,         5'd0,  0, 2'b00, 0, 1, 1);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_vec(tbl[i]);
    end

    reset_mid_write();

    for (int n = 0; n < 40; n++) begin
      v = mk(1'b0, 32'h0, 5'd0, 0, -1, 0, 1'b0, 32'h0, 5'd0, 0, 2'b00, 0, 1'b0, 1'b0);
      v.do_rd   = ($urandom_range(0, 1) == 1);
      v.do_wr   = v.do_rd ? ($urandom_range(0, 1) == 1) : 1'b1;
      v.rd_addr = $urandom & 32'hFFFF_FFFC;
      v.rd_len  = 5'($urandom_range(0, 31));
      v.rd_last_beat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : int'(v.rd_len);
      v.rd_bad_beat  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : -1;
      v.rd_base = $urandom;
      v.ar_dly  = int'($urandom_range(0, 3));
      v.wr_addr = $urandom & 32'hFFFF_FFFC;
      v.wr_len  = 5'($urandom_range(0, 31));
      v.wr_last_beat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : int'(v.wr_len);
      v.bresp   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.wr_base = $urandom;
      v.aw_dly  = int'($urandom_range(0, 3));
      v.b_dly   = int'($urandom_range(0, 4));
      v.stall   = ($urandom_range(0, 1) == 1);
      v.exp_err = model_err(v);
      do_reset();
      run_vec(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_axi_master.md
# dma_axi_master

Memory-side port adapter directly downstream of the DMA engine core. Accepts the engine's burst read and burst write requests (address, length, valid/ready) and drives them onto an AXI4 master interface, passing read data back to and write data from the engine. Read and write paths are independent FSMs, each with one outstanding burst, so a read and a write may be in flight simultaneously. Also latches AXI error responses and protocol mismatches into a sticky error flag.

## Interface
- DATA_WIDTH, 32, data bus width in bits; only 32 is supported.
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- rd_req_addr / rd_req_len / rd_req_valid  input  32/5/1  engine read request; len = beats-1
- rd_req_ready  output  1  read request accepted when valid & ready
- rd_rdata / rd_last / rd_valid  output  32/1/1  read data beat to engine
- rd_ready  input  1  engine accepts read beat
- wr_req_addr / wr_req_len / wr_req_valid  input  32/5/1  engine write request; len = beats-1
- wr_req_ready  output  1  write request accepted when valid & ready
- wr_data / wr_valid / wr_last  input  32/1/1  write data beat from engine
- wr_ready  output  1  adapter accepts write beat
- m_axi_araddr / arlen / arsize / arburst / arvalid  output  32/8/3/2/1  AXI read address
- m_axi_arready  input  1
- m_axi_rdata / rresp / rlast / rvalid  input  32/2/1/1  AXI read data
- m_axi_rready  output  1
- m_axi_awaddr / awlen / awsize / awburst / awvalid  output  32/8/3/2/1  AXI write address
- m_axi_awready  input  1
- m_axi_wdata / wstrb / wlast / wvalid  output  32/4/1/1  AXI write data
- m_axi_wready  input  1
- m_axi_bresp / bvalid  input  2/1  AXI write response
- m_axi_bready  output  1
- err  output  1  sticky error flag, cleared only by rst
- busy  output  1  either FSM not idle

## Operation
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: rd_req_ready=1. On rd_req_valid, latch addr and len, clear the beat counter, and go to R_ADDR.
  - R_ADDR: arvalid=1. On arready, go to R_DATA.
  - R_DATA: combinational pass-through. rd_rdata=rdata, rd_valid=rvalid, rd_last=rlast, rready=rd_ready. Each rvalid&rready increments the beat counter. On the rlast handshake, return to R_IDLE.
- Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: wr_req_ready=1. On wr_req_valid, latch addr and len, clear the beat counter, and go to W_ADDR.
  - W_ADDR: awvalid=1. On awready, go to W_DATA.
  - W_DATA: pass-through. wdata=wr_data, wvalid=wr_valid, wlast=wr_last, wr_ready=wready. On the wlast handshake, go to W_RESP.
  - W_RESP: bready=1. On bvalid, return to W_IDLE.
- Outside its data state, each path forces its valid/ready outputs to 0.
- Constant fields: arsize=awsize=3'b010, arburst=awburst=2'b01 (INCR), wstrb=4'hF.
- arlen and awlen are the latched len zero-extended to 8 bits.
- Error sources. err is set on any of the following, and the transfer still completes normally:
  - rresp != 0 on any handshaked beat;
  - bresp != 0;
  - rlast handshaked with beat counter != len, or a beat handshaked at counter == len without rlast;
  - the same two mismatch checks on the write side with wlast.
- Beat counters are 5 bits. No wrap: the maximum is 31 (len=31, 32 beats).
- 4 KB boundary crossing is not checked; the engine must not issue such bursts.

## Timing
- Reset: all FSMs go to IDLE and the counters and err clear.
- Output values in reset:
  - valids, m_axi_rready, m_axi_bready, wr_ready, rd_valid: 0
  - rd_req_ready, wr_req_ready: 0 during rst, then 1 in IDLE
  - m_axi_araddr, m_axi_awaddr, arlen, awlen: 0
  - err, busy: 0
- Request acceptance: the handshake in cycle N gives arvalid/awvalid=1 in cycle N+1. Minimum request-to-AR latency is 1 cycle.
- AR/AW: address and len are held stable while valid and ready are low. valid never drops before the handshake.
- Data paths are combinational. There is zero-cycle latency between AXI and the engine, and backpressure propagates in the same cycle.
- The next request can be accepted one cycle after the last beat (read) or after the bvalid cycle (write).
- Simultaneous events:
  - A read and a write proceed concurrently with no interaction.
  - An arready arriving in the same cycle arvalid first rises is a valid handshake.
- Reset asserted mid-burst aborts immediately. No AXI cleanup is attempted; the system is reset as a whole.

## Test plan
- Read, len=3, addr 0x1000_0000, arready after 2 cycles, rdata 0xA0..0xA3 with rready toggling.
  - Required: araddr=0x1000_0000, arlen=3, 4 beats delivered in order, rd_last on 0xA3, rd_req_ready back to 1 the cycle after.
- Write, len=7, addr 0x2000_0040, data 0..7 with wready stalls, bvalid 3 cycles after wlast with bresp=0.
  - Required: awlen=7, 8 beats in order, wlast only on beat 7, err=0, return to W_IDLE.
- Concurrent read len=0 and write len=15 issued in the same cycle.
  - Required: both AR and AW valid in the next cycle, and both complete independently.
- Error cases, each from reset:
  - rresp=2'b10 on beat 1: err=1.
  - bresp=2'b11: err=1.
  - rlast on beat 2 of a len=3 burst: err=1.
- Reset asserted in W_DATA after beat 2.
  - Required: next cycle all valids=0, err=0; the following cycle wr_req_ready=1. A subsequent len=0 write completes.
- Max burst, len=31 read.
  - Required: arlen=8'd31, 32 beats, no error, beat counter does not wrap.
